param_main_memory: RTL and testbench

Parametrised main memory behind the data cache: accepts single-word writes with byte enables and whole-block reads, each completing after a fixed, configurable latency with a one-cycle `ready` pulse. It generalises the fixed four-word, four-cycle backing store in word width, block size and latency. It latches each request at acceptance, so the cache controller may change `address` and `data_in` while the request is in flight.

---
 rtl/param_main_memory.sv | 112 +++++++++++
 tb/tb_param_main_memory.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/param_main_memory.sv
// Backing store behind the data cache: byte-masked single-word writes and whole-block
// reads, each completing LATENCY cycles after acceptance with a one-cycle ready pulse.
module param_main_memory #(
    parameter  int ADDR_W        = 10,
    parameter  int WORD_W        = 32,
    parameter  int WORDS_PER_BLK = 4,
    parameter  int LATENCY       = 4,
    localparam int BLOCK_W       = WORD_W * WORDS_PER_BLK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                read_mem,
    input  logic                write_mem,
    input  logic [ADDR_W-1:0]   address,
    input  logic [WORD_W-1:0]   data_in,
    input  logic [WORD_W/8-1:0] byte_en,
    output logic                ready,
    output logic                busy,
    output logic [BLOCK_W-1:0]  block_data
);

    localparam int BE_W  = WORD_W / 8;
    localparam int OFF_W = $clog2(WORDS_PER_BLK);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                ready_q;
    logic [BLOCK_W-1:0]  blk_q;
    logic                rd_done, wr_done;
    logic [BLOCK_W-1:0]  rd_blk;

    logic [WORD_W-1:0]   mem [DEPTH];

    // State register plus the request latches that travel with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            ready_q <= 1'b0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            ready_q <= rd_done | wr_done;
            if (rd_done) blk_q <= rd_blk;
        end
    end

    // Next state: write wins over a simultaneous read, which is simply dropped
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        unique case (state_q)
            IDLE: begin
                if (write_mem) begin
                    state_d = WR_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    addr_d  = address;
                    data_d  = data_in;
                    be_d    = byte_en;
                end else if (read_mem) begin
                    state_d = RD_WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    addr_d  = {address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; the block is gathered from memory at the completion edge itself
    always_comb begin
        busy    = (state_q != IDLE);
        rd_done = (state_q == RD_WAIT) && (cnt_q == '0);
        wr_done = (state_q == WR_WAIT) && (cnt_q == '0);
        rd_blk  = '0;
        for (int w = 0; w < WORDS_PER_BLK; w++)
            rd_blk[BLOCK_W-1-w*WORD_W -: WORD_W] = mem[addr_q | ADDR_W'(w)];
    end

    // Storage is deliberately not reset; an aborted write never reaches wr_done
    always_ff @(posedge clk) begin
        if (wr_done) begin
            for (int i = 0; i < BE_W; i++)
                if (be_q[i]) mem[addr_q][8*i +: 8] <= data_q[8*i +: 8];
        end
    end

    assign ready      = ready_q;
    assign block_data = blk_q;

endmodule

// File: tb/tb_param_main_memory.sv
// Drives three memory configurations in lock-step and compares each against its own
// behavioural model every cycle.
module tb_param_main_memory;

  localparam int NK = 3;

  function automatic int lat_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 7;
    endcase
  endfunction

  function automatic int wpb_of(input int k);
    return (k == 0) ? 4 : 8;
  endfunction

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd = 1'b0, wr = 1'b0;
  logic [9:0]    addr = '0;
  logic [31:0]   din = '0;
  logic [3:0]    be = '0;
  logic [NK-1:0] rdy, bsy;
  logic [127:0]  blk0;
  logic [255:0]  blk1, blk2;
  logic [255:0]  blkv [NK];

  param_main_memory #(.ADDR_W(10), .WORD_W(32), .WORDS_PER_BLK(4), .LATENCY(4)) u0 (
    .clk(clk), .rst(rst), .read_mem(rd), .write_mem(wr), .address(addr), .data_in(din),
    .byte_en(be), .ready(rdy[0]), .busy(bsy[0]), .block_data(blk0));
  param_main_memory #(.ADDR_W(10), .WORD_W(32), .WORDS_PER_BLK(8), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .read_mem(rd), .write_mem(wr), .address(addr), .data_in(din),
    .byte_en(be), .ready(rdy[1]), .busy(bsy[1]), .block_data(blk1));
  param_main_memory #(.ADDR_W(10), .WORD_W(32), .WORDS_PER_BLK(8), .LATENCY(7)) u2 (
    .clk(clk), .rst(rst), .read_mem(rd), .write_mem(wr), .address(addr), .data_in(din),
    .byte_en(be), .ready(rdy[2]), .busy(bsy[2]), .block_data(blk2));

  always #5 clk = ~clk;

  always_comb begin
    blkv[0] = {128'b0, blk0};
    blkv[1] = blk1;
    blkv[2] = blk2;
  end

  // Model: per-configuration memory image, one in-flight op, expected block
  logic [31:0]  mm [NK][64];
  logic         act [NK];
  int           done_c [NK];
  logic         op_wr [NK];
  int           op_a [NK];
  logic [31:0]  op_d [NK];
  logic [3:0]   op_be [NK];
  logic [255:0] eblk [NK];
  int           cyc = 0;
  int           checks = 0, passes = 0;
  logic         chk_on = 1'b0;
  logic         er;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s dut%0d: got %h expected %h", nm, k, a, e);
  endtask

  task automatic apply(input int k);
    int base;
    if (op_wr[k]) begin
      for (int i = 0; i < 4; i++)
        if (op_be[k][i]) mm[k][op_a[k]][8*i +: 8] = op_d[k][8*i +: 8];
    end else begin
      base = op_a[k] - (op_a[k] % wpb_of(k));
      eblk[k] = '0;
      for (int w = 0; w < wpb_of(k); w++)
        eblk[k][(wpb_of(k)-1-w)*32 +: 32] = mm[k][base + w];
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < NK; k++) begin
        er = 1'b0;
        if (act[k] && cyc == done_c[k]) begin
          apply(k);
          act[k] = 1'b0;
          er = 1'b1;
        end
        chk("ready", k, 256'(rdy[k]), 256'(er));
        chk("busy", k, 256'(bsy[k]), 256'(act[k]));
        chk("block_data", k, blkv[k], eblk[k]);
      end
    end
  end

  // Called just after an accept edge; all configurations were idle there
  task automatic post_accept(input logic r, input logic w, input int a, input logic [31:0] d,
                             input logic [3:0] b);
    if (r | w) begin
      for (int k = 0; k < NK; k++) begin
        act[k]    = 1'b1;
        done_c[k] = cyc + lat_of(k);
        op_wr[k]  = w;
        op_a[k]   = a;
        op_d[k]   = d;
        op_be[k]  = b;
      end
    end
  endtask

  task automatic issue(input logic r, input logic w, input int a, input logic [31:0] d,
                       input logic [3:0] b, input logic scramble, input logic poke);
    int t0;
    rd = r; wr = w; addr = 10'(a); din = d; be = b;
    @(posedge clk); #1;
    t0 = cyc;
    rd = 1'b0; wr = 1'b0;
    if (scramble) begin
      addr = 10'($urandom); din = $urandom; be = 4'($urandom);
    end
    post_accept(r, w, a, d, b);
    if (poke) begin
      @(negedge clk); rd = 1'b1;
      @(negedge clk); rd = 1'b0;
    end
    while (cyc < t0 + 7) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < NK; k++) begin
      chk("rst_ready", k, 256'(rdy[k]), 256'(0));
      chk("rst_busy", k, 256'(bsy[k]), 256'(0));
      chk("rst_block", k, blkv[k], 256'(0));
      act[k]  = 1'b0;
      eblk[k] = '0;
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();
    chk_on = 1'b1;

    for (int a = 0; a < 64; a++) issue(1'b0, 1'b1, a, $urandom, 4'hF, 1'b0, 1'b0);

    issue(1'b0, 1'b1, 'h005, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 'h006, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("lit_deadbeef", 0, 256'(blkv[0][95:64]), 256'(32'hDEADBEEF));
    chk("lit_deadbeef", 1, 256'(blkv[1][95:64]), 256'(32'hDEADBEEF));

    issue(1'b0, 1'b1, 'h010, 32'h11223344, 4'hF, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 'h010, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 'h010, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("lit_byte_en", 0, 256'(blkv[0][127:96]), 256'(32'h11BB33DD));
    chk("lit_byte_en", 1, 256'(blkv[1][255:224]), 256'(32'h11BB33DD));

    issue(1'b1, 1'b1, 'h011, 32'h55667788, 4'hF, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 'h011, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("lit_both_req", 0, 256'(blkv[0][95:64]), 256'(32'h55667788));

    issue(1'b0, 1'b1, 'h012, 32'h99AABBCC, 4'hF, 1'b1, 1'b1);
    issue(1'b1, 1'b0, 'h012, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("lit_capture", 0, 256'(blkv[0][63:32]), 256'(32'h99AABBCC));

    // Abort a write when the latency-4 counter sits at 1
    issue(1'b0, 1'b1, 'h020, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0);
    wr = 1'b1; addr = 10'h020; din = 32'h12345678; be = 4'hF;
    @(posedge clk); #1;
    wr = 1'b0;
    post_accept(1'b0, 1'b1, 'h020, 32'h12345678, 4'hF);
    repeat (3) @(negedge clk);
    do_reset();
    issue(1'b1, 1'b0, 'h020, 32'h0, 4'h0, 1'b0, 1'b0);
    chk("lit_abort", 0, 256'(blkv[0][127:96]), 256'(32'hCAFEF00D));
    chk("lit_abort", 1, 256'(blkv[1][255:224]), 256'(32'h12345678));
    chk("lit_abort", 2, 256'(blkv[2][255:224]), 256'(32'hCAFEF00D));

    issue(1'b0, 1'b1, 'h021, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 'h021, 32'h0, 4'h0, 1'b0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: issue(1'b1, 1'b0, $urandom_range(0, 63), $urandom, 4'($urandom), 1'b1, 1'b0);
        1: issue(1'b0, 1'b1, $urandom_range(0, 63), $urandom, 4'($urandom), 1'b0, 1'b0);
        2: issue(1'b1, 1'b1, $urandom_range(0, 63), $urandom, 4'($urandom), 1'b1, 1'b0);
        default: issue(1'b0, 1'b1, $urandom_range(0, 63), $urandom, 4'($urandom), 1'b1, 1'b1);
      endcase
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
